fft_peak_extractor: RTL and testbench

Consumer end of the FFT magnitude read-out port. After `done_FFT`, it drives `index` through the non-mirrored half of the spectrum and captures each `magnitude` on `magnitude_ready`. It reduces every equal-width frequency band to its strongest bin and emits one peak record per band over a valid/ready stream. Those records feed the fingerprint/hash stage.

---
 rtl/fft_peak_extractor.sv | 151 +++++++++++++++
 tb/tb_fft_peak_extractor.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_peak_extractor.sv
// Scans bins 0..FFT_LENGTH/2-1 of an FFT magnitude port after done_FFT and emits the strongest
// bin of each equal-width band as a peak record over a valid/ready stream (2-entry output FIFO).
module fft_peak_extractor #(
   parameter int unsigned FFT_LENGTH = 1024,
   parameter int unsigned MAG_WIDTH  = 16,
   parameter int unsigned NUM_BANDS  = 8,
   parameter int unsigned THRESHOLD  = 16,
   parameter int unsigned SKIP_DC    = 1,
   localparam int unsigned IW = $clog2(FFT_LENGTH),
   localparam int unsigned BW = (NUM_BANDS > 1) ? $clog2(NUM_BANDS) : 1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 done_FFT,
   input  logic [MAG_WIDTH-1:0] magnitude,
   input  logic                 magnitude_ready,
   output logic [IW-1:0]        index,
   output logic                 peak_valid,
   input  logic                 peak_ready,
   output logic [IW-1:0]        peak_bin,
   output logic [MAG_WIDTH-1:0] peak_mag,
   output logic [BW-1:0]        peak_band,
   output logic                 peak_found,
   output logic                 busy,
   output logic                 frame_done
);

   localparam int unsigned HALF    = FFT_LENGTH / 2;
   localparam int unsigned BPB     = HALF / NUM_BANDS;
   localparam int unsigned BPB_LOG = $clog2(BPB);
   localparam int unsigned RW      = BW + IW + MAG_WIDTH + 1;

   localparam logic [IW-1:0] BIN_MASK = IW'(BPB - 1);
   localparam logic [IW-1:0] LAST_BIN = IW'(HALF - 1);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] SCAN  = 2'd1;
   localparam logic [1:0] FLUSH = 2'd2;
   localparam logic [1:0] DONE  = 2'd3;

   logic [1:0]           state_q, state_d;
   logic                 done_q;
   logic [IW-1:0]        index_q, index_d;
   logic [MAG_WIDTH-1:0] max_mag_q, max_mag_d;
   logic [IW-1:0]        max_bin_q, max_bin_d;
   logic [RW-1:0]        fifo_q [2];
   logic [RW-1:0]        fifo_d [2];
   logic [1:0]           count_q, count_d;

   logic                 rise;
   logic                 band_first, band_last;
   logic [MAG_WIDTH-1:0] score, cand_mag;
   logic [IW-1:0]        cand_bin;
   logic                 take, consume, push, pop;
   logic [BW-1:0]        band;
   logic [RW-1:0]        push_rec;

   assign index      = index_q;
   assign peak_valid = (count_q != 2'd0);
   assign {peak_band, peak_bin, peak_mag, peak_found} = fifo_q[0];
   assign busy       = (state_q != IDLE);
   assign frame_done = (state_q == DONE);

   always_comb begin
      rise       = done_FFT & ~done_q;
      band_first = (index_q & BIN_MASK) == '0;
      band_last  = (index_q & BIN_MASK) == BIN_MASK;
      band       = BW'(index_q >> BPB_LOG);
      score      = ((SKIP_DC != 0) && (index_q == '0)) ? '0 : magnitude;
      // Strictly greater keeps the lowest bin on ties; the first bin always seeds the band.
      take       = band_first || (score > max_mag_q);
      cand_mag   = take ? score : max_mag_q;
      cand_bin   = take ? index_q : max_bin_q;
      pop        = peak_valid && peak_ready;
      consume    = (state_q == SCAN) && magnitude_ready && (!band_last || (count_q != 2'd2));
      push       = consume && band_last;
      push_rec   = {band, cand_bin, cand_mag, (cand_mag > MAG_WIDTH'(THRESHOLD))};
   end

   always_comb begin
      state_d   = state_q;
      index_d   = index_q;
      max_mag_d = max_mag_q;
      max_bin_d = max_bin_q;
      unique case (state_q)
         IDLE: begin
            index_d = '0;
            if (rise) state_d = SCAN;
         end
         SCAN: begin
            if (consume) begin
               if (band_last) begin
                  max_mag_d = '0;
                  max_bin_d = '0;
               end else begin
                  max_mag_d = cand_mag;
                  max_bin_d = cand_bin;
               end
               // The index parks on the last bin so no mirrored bin is ever requested.
               if (index_q == LAST_BIN) state_d = FLUSH;
               else                     index_d = index_q + 1'b1;
            end
         end
         FLUSH: begin
            if (count_q == 2'd0) state_d = DONE;
         end
         DONE: begin
            state_d = IDLE;
            index_d = '0;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      fifo_d  = fifo_q;
      count_d = count_q;
      if (pop) begin
         fifo_d[0] = fifo_q[1];
         count_d   = count_q - 2'd1;
      end
      if (push) begin
         if (count_d == 2'd0) fifo_d[0] = push_rec;
         else                 fifo_d[1] = push_rec;
         count_d = count_d + 2'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         done_q    <= 1'b0;
         index_q   <= '0;
         max_mag_q <= '0;
         max_bin_q <= '0;
         fifo_q[0] <= '0;
         fifo_q[1] <= '0;
         count_q   <= 2'd0;
      end else begin
         state_q   <= state_d;
         done_q    <= done_FFT;
         index_q   <= index_d;
         max_mag_q <= max_mag_d;
         max_bin_q <= max_bin_d;
         fifo_q[0] <= fifo_d[0];
         fifo_q[1] <= fifo_d[1];
         count_q   <= count_d;
      end
   end

endmodule

// File: tb/tb_fft_peak_extractor.sv
// Drives two extractors (SKIP_DC=1 and SKIP_DC=0) from a shared spectrum table and checks
// every peak record against a per-band argmax model, plus timing and stall corner cases.
module tb_fft_peak_extractor;

   localparam int FFT_LENGTH = 1024;
   localparam int MAG_WIDTH  = 16;
   localparam int NUM_BANDS  = 8;
   localparam int THRESHOLD  = 16;
   localparam int HALF       = FFT_LENGTH / 2;
   localparam int BPB        = HALF / NUM_BANDS;
   localparam int IW         = 10;
   localparam int BW         = 3;

   typedef struct packed {
      logic [BW-1:0]        band;
      logic [IW-1:0]        bin;
      logic [MAG_WIDTH-1:0] mag;
      logic                 found;
   } rec_t;

   typedef struct {
      int bin_a; int mag_a; int bin_b; int mag_b; int base;
      int mr_mode; int pr_mode; int hold;
      int chk_band; int exp_bin; int exp_mag; int exp_found;
      int exp_bin0; int exp_mag0; int exp_found0; int exp_len;
   } vec_t;

   logic clk = 1'b0;
   logic reset, done_FFT, magnitude_ready, peak_ready;
   logic [MAG_WIDTH-1:0] spectrum [HALF];

   logic [IW-1:0]        index_a, pbin_a, index_z, pbin_z;
   logic [MAG_WIDTH-1:0] mag_a, pmag_a, mag_z, pmag_z;
   logic [BW-1:0]        pband_a, pband_z;
   logic                 pv_a, pfound_a, busy_a, fdone_a;
   logic                 pv_z, pfound_z, busy_z, fdone_z;

   assign mag_a = spectrum[index_a[IW-2:0]];
   assign mag_z = spectrum[index_z[IW-2:0]];

   fft_peak_extractor #(.FFT_LENGTH(FFT_LENGTH), .MAG_WIDTH(MAG_WIDTH), .NUM_BANDS(NUM_BANDS),
                        .THRESHOLD(THRESHOLD), .SKIP_DC(1)) dut (
      .clk(clk), .reset(reset), .done_FFT(done_FFT), .magnitude(mag_a),
      .magnitude_ready(magnitude_ready), .index(index_a), .peak_valid(pv_a),
      .peak_ready(peak_ready), .peak_bin(pbin_a), .peak_mag(pmag_a), .peak_band(pband_a),
      .peak_found(pfound_a), .busy(busy_a), .frame_done(fdone_a));

   fft_peak_extractor #(.FFT_LENGTH(FFT_LENGTH), .MAG_WIDTH(MAG_WIDTH), .NUM_BANDS(NUM_BANDS),
                        .THRESHOLD(THRESHOLD), .SKIP_DC(0)) dut_dc (
      .clk(clk), .reset(reset), .done_FFT(done_FFT), .magnitude(mag_z),
      .magnitude_ready(magnitude_ready), .index(index_z), .peak_valid(pv_z),
      .peak_ready(peak_ready), .peak_bin(pbin_z), .peak_mag(pmag_z), .peak_band(pband_z),
      .peak_found(pfound_z), .busy(busy_z), .frame_done(fdone_z));

   always #5 clk = ~clk;

   int   checks = 0;
   int   passes = 0;
   int   mr_mode = 0;   // 0 always ready, 1 toggle, 2 random
   int   pr_mode = 0;   // 0 always ready, 1 held low, 2 random
   rec_t got_a[$];
   rec_t got_z[$];
   int   fd_a, fd_z, idx_viol;
   logic [IW-1:0] last_idx;
   logic last_mr;
   vec_t vecs [5];

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got === exp) passes++;
      else $display("FAIL %s: got %0h required %0h", name, got, exp);
   endtask

   // Reference: argmax over each band's bins, first occurrence wins, DC optionally zeroed.
   function automatic rec_t model_rec(input int band, input bit skip_dc);
      rec_t r;
      int best_bin, best_mag, m;
      best_bin = -1;
      best_mag = -1;
      for (int k = band * BPB; k < (band + 1) * BPB; k++) begin
         m = (skip_dc && k == 0) ? 0 : int'(spectrum[k]);
         if (m > best_mag) begin
            best_mag = m;
            best_bin = k;
         end
      end
      r.band  = BW'(band);
      r.bin   = IW'(best_bin);
      r.mag   = MAG_WIDTH'(best_mag);
      r.found = (best_mag > THRESHOLD);
      return r;
   endfunction

   task automatic sample();
      rec_t r;
      if (pv_a && peak_ready) begin
         r = {pband_a, pbin_a, pmag_a, pfound_a};
         got_a.push_back(r);
      end
      if (pv_z && peak_ready) begin
         r = {pband_z, pbin_z, pmag_z, pfound_z};
         got_z.push_back(r);
      end
      if (fdone_a) fd_a++;
      if (fdone_z) fd_z++;
      if (index_a != last_idx && index_a != '0 && !last_mr) idx_viol++;
      last_idx = index_a;
      last_mr  = magnitude_ready;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      case (mr_mode)
         1:       magnitude_ready = ~magnitude_ready;
         2:       magnitude_ready = 1'($urandom_range(0, 1));
         default: magnitude_ready = 1'b1;
      endcase
      case (pr_mode)
         1:       peak_ready = 1'b0;
         2:       peak_ready = 1'b1 & 1'($urandom_range(0, 1));
         default: peak_ready = 1'b1;
      endcase
      @(negedge clk);
      sample();
   endtask

   task automatic load_spec(input int bin_a, input int mag_a_v, input int bin_b, input int mag_b_v,
                            input int base);
      for (int k = 0; k < HALF; k++) spectrum[k] = MAG_WIDTH'(base);
      if (bin_a >= 0) spectrum[bin_a] = MAG_WIDTH'(mag_a_v);
      if (bin_b >= 0) spectrum[bin_b] = MAG_WIDTH'(mag_b_v);
   endtask

   task automatic run_frame(input string tag, input int budget, input int exp_len, input int hold,
                            input int reset_at);
      int fd_cycle;
      rec_t ra, rz;
      got_a.delete();
      got_z.delete();
      fd_a = 0;
      fd_z = 0;
      idx_viol = 0;
      fd_cycle = -1;
      done_FFT = 1'b1;
      for (int k = 1; k <= budget; k++) begin
         tick();
         if (k == 1) check({tag, "_start"}, {busy_a, index_a}, {1'b1, IW'(0)});
         if (k == 3 || k == 102) done_FFT = 1'b0;
         if (k == 100) done_FFT = 1'b1;  // must be ignored mid-scan
         if (hold != 0 && (k == 400 || k == 410)) begin
            check({tag, "_hold_index"}, index_a, IW'(191));
            check({tag, "_hold_head"}, {pv_a, pband_a, pbin_a, pmag_a, pfound_a},
                  {1'b1, model_rec(0, 1'b1)});
            if (k == 410) pr_mode = 0;
         end
         if (reset_at != 0 && index_a == IW'(300)) begin
            reset = 1'b1;
            tick();
            check({tag, "_reset_outputs"},
                  {index_a, pv_a, pbin_a, pmag_a, pband_a, pfound_a, busy_a, fdone_a}, '0);
            reset = 1'b0;
            got_a.delete();
            fd_a = 0;
            for (int j = 0; j < 20; j++) tick();
            check({tag, "_reset_quiet"}, {32'(got_a.size()), 31'(fd_a), busy_a}, '0);
            return;
         end
         if (fdone_a && fd_cycle < 0) fd_cycle = k;
         if (fd_cycle > 0 && k == fd_cycle + 1) begin
            check({tag, "_idle_after_done"}, busy_a, 1'b0);
            break;
         end
      end
      check({tag, "_frame_done_seen"}, (fd_cycle > 0), 1'b1);
      if (exp_len > 0) check({tag, "_frame_len"}, fd_cycle, exp_len);
      check({tag, "_records_a"}, got_a.size(), NUM_BANDS);
      check({tag, "_records_dc0"}, got_z.size(), NUM_BANDS);
      check({tag, "_frame_done_pulses"}, {fd_a, fd_z}, {32'd1, 32'd1});
      check({tag, "_index_only_on_ready"}, idx_viol, 0);
      for (int b = 0; b < NUM_BANDS; b++) begin
         ra = (b < got_a.size()) ? got_a[b] : '0;
         rz = (b < got_z.size()) ? got_z[b] : '0;
         check($sformatf("%s_band%0d", tag, b), ra, model_rec(b, 1'b1));
         check($sformatf("%s_dc0_band%0d", tag, b), rz, model_rec(b, 1'b0));
      end
   endtask

   initial begin
      vec_t v;
      rec_t r;
      //            bin_a mag_a bin_b mag_b base mr pr hold band ebin emag ef  ebin0 emag0 ef0 len
      vecs[0] = '{   8,  100,   70,  200,  1,  0, 0, 0,   1,  70, 200, 1,   70,  200, 1, 515};
      vecs[1] = '{ 130,  500,  150,  500, 16,  0, 0, 0,   2, 130, 500, 1,  130,  500, 1, 515};
      vecs[2] = '{   0, 9999,   -1,    0,  5,  0, 0, 0,   0,   1,   5, 0,    0, 9999, 1, 515};
      vecs[3] = '{   8,  100,   70,  200,  1,  0, 1, 1,   0,   8, 100, 1,    8,  100, 1,   0};
      vecs[4] = '{   8,  100,   70,  200,  1,  1, 0, 0,   1,  70, 200, 1,   70,  200, 1,   0};

      reset = 1'b1;
      done_FFT = 1'b0;
      magnitude_ready = 1'b0;
      peak_ready = 1'b0;
      last_idx = '0;
      last_mr = 1'b0;
      load_spec(-1, 0, -1, 0, 1);
      for (int k = 0; k < 3; k++) tick();
      reset = 1'b0;
      check("reset_state",
            {index_a, pv_a, pbin_a, pmag_a, pband_a, pfound_a, busy_a, fdone_a}, '0);

      for (int i = 0; i < 5; i++) begin
         v = vecs[i];
         load_spec(v.bin_a, v.mag_a, v.bin_b, v.mag_b, v.base);
         mr_mode = v.mr_mode;
         pr_mode = v.pr_mode;
         run_frame($sformatf("vec%0d", i), 3000, v.exp_len, v.hold, 0);
         r = (v.chk_band < got_a.size()) ? got_a[v.chk_band] : '0;
         check($sformatf("vec%0d_directed", i), {r.bin, r.mag, r.found},
               {IW'(v.exp_bin), MAG_WIDTH'(v.exp_mag), 1'(v.exp_found)});
         r = (v.chk_band < got_z.size()) ? got_z[v.chk_band] : '0;
         check($sformatf("vec%0d_directed_dc0", i), {r.bin, r.mag, r.found},
               {IW'(v.exp_bin0), MAG_WIDTH'(v.exp_mag0), 1'(v.exp_found0)});
         for (int k = 0; k < 4; k++) tick();
      end

      // Abort mid-scan, then a clean rescan of the same spectrum.
      load_spec(8, 100, 70, 200, 1);
      mr_mode = 1;
      pr_mode = 0;
      run_frame("reset_abort", 3000, 0, 0, 1);
      mr_mode = 0;
      run_frame("rescan", 3000, 515, 0, 0);

      for (int f = 0; f < 3; f++) begin
         for (int k = 0; k < HALF; k++)
            spectrum[k] = ($urandom_range(0, 3) == 0) ? MAG_WIDTH'($urandom_range(0, 20))
                                                        : MAG_WIDTH'($urandom_range(0, 600));
         mr_mode = 2;
         pr_mode = 2;
         run_frame($sformatf("rand%0d", f), 5000, 0, 0, 0);
         for (int k = 0; k < 4; k++) tick();
      end

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
